// File: rtl/rand_fetch_fta32.sv
// FTA 32-bit bus types plus a bus initiator that keeps a small prefetch FIFO
// stocked with words drawn from the multi-stream random number generator.
package fta_bus_pkg;
  localparam logic [2:0] CTI_CLASSIC = 3'd0;
  localparam logic [2:0] CTI_ERC     = 3'd7;

  typedef struct packed {
    logic        cyc;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [9:0]  tid;
  } fta_cmd_request32_t;

  typedef struct packed {
    logic        ack;
    logic        stall;
    logic [9:0]  tid;
    logic [31:0] dat;
  } fta_cmd_response32_t;
endpackage

module rand_fetch_fta32
  import fta_bus_pkg::*;
#(
  parameter logic [31:0] RAND_ADDR  = 32'hFEE10000,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [7:0]  TIMEOUT    = 8'd255,
  parameter logic [5:0]  CID        = 6'd1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_i,
  input  logic [9:0]                    stream_i,
  output fta_cmd_request32_t            req_o,
  input  fta_cmd_response32_t           resp_i,
  input  logic                          rd_i,
  output logic [31:0]                   dat_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          err_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, SSTRM, WSTRM, SREAD, WREAD, SADV, WADV} state_t;

  state_t             state_reg, state_next;
  fta_cmd_request32_t req_reg, req_next;
  logic [3:0]         seq_reg;
  logic [9:0]         tid_reg;
  logic [9:0]         stream_reg;
  logic               stream_valid_reg;
  logic               rsv_reg;
  logic [7:0]         tmo_reg;
  logic               err_reg;

  logic [31:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]        count_reg;

  logic in_wait, issue, ack_hit, tmo_hit, push, pop, room, stream_stale;

  assign in_wait      = (state_reg == WSTRM) || (state_reg == WREAD) || (state_reg == WADV);
  assign issue        = (state_reg == SSTRM) || (state_reg == SREAD) || (state_reg == SADV);
  // Only the ack carrying the tid we issued counts; stale acks fall through.
  assign ack_hit      = in_wait && resp_i.ack && (resp_i.tid == tid_reg);
  assign tmo_hit      = in_wait && !ack_hit && (tmo_reg == TIMEOUT);
  assign push         = (state_reg == WREAD) && ack_hit;
  assign pop          = rd_i && (count_reg != '0);
  assign room         = ({1'b0, count_reg} + {{(AW+1){1'b0}}, rsv_reg}) < DEPTH_W;
  assign stream_stale = !stream_valid_reg || (stream_i != stream_reg);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (en_i && stream_stale) state_next = SSTRM;
        else if (en_i && room)    state_next = SREAD;
      end
      SSTRM: state_next = WSTRM;
      SREAD: state_next = WREAD;
      SADV:  state_next = WADV;
      WSTRM: begin
        if (ack_hit)      state_next = IDLE;
        else if (tmo_hit) state_next = SSTRM;
      end
      WREAD: begin
        if (ack_hit)      state_next = SADV;
        else if (tmo_hit) state_next = SREAD;
      end
      WADV: begin
        if (ack_hit)      state_next = IDLE;
        else if (tmo_hit) state_next = SADV;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request is registered: cyc shows the cycle after the S* state and holds through stall.
  always_comb begin
    req_next = req_reg;
    if (req_reg.cyc && !resp_i.stall) req_next = '0;
    case (state_reg)
      SSTRM: begin
        req_next     = '0;
        req_next.cyc = 1'b1;
        req_next.we  = 1'b1;
        req_next.sel = 4'hF;
        req_next.adr = RAND_ADDR + 32'd4;
        req_next.dat = {22'h0, stream_i};
        req_next.cti = CTI_ERC;
        req_next.tid = {CID, seq_reg};
      end
      SREAD: begin
        req_next     = '0;
        req_next.cyc = 1'b1;
        req_next.sel = 4'hF;
        req_next.adr = RAND_ADDR;
        req_next.cti = CTI_CLASSIC;
        req_next.tid = {CID, seq_reg};
      end
      SADV: begin
        req_next     = '0;
        req_next.cyc = 1'b1;
        req_next.we  = 1'b1;
        req_next.sel = 4'hF;
        req_next.adr = RAND_ADDR;
        req_next.cti = CTI_ERC;
        req_next.tid = {CID, seq_reg};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_reg          <= '0;
      seq_reg          <= '0;
      tid_reg          <= '0;
      stream_reg       <= '0;
      stream_valid_reg <= 1'b0;
      rsv_reg          <= 1'b0;
      tmo_reg          <= '0;
      err_reg          <= 1'b0;
    end else begin
      req_reg <= req_next;
      if (issue) begin
        seq_reg <= seq_reg + 4'd1;
        tid_reg <= {CID, seq_reg};
        tmo_reg <= '0;
      end else if (in_wait && !req_reg.cyc) begin
        tmo_reg <= tmo_reg + 8'd1;
      end
      if (state_reg == SSTRM) stream_reg <= stream_i;
      if ((state_reg == WSTRM) && ack_hit) stream_valid_reg <= 1'b1;
      // The reservation survives read retries and is only dropped by the push.
      if (state_reg == SREAD) rsv_reg <= 1'b1;
      else if (push)          rsv_reg <= 1'b0;
      if (tmo_hit) err_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_reg] <= resp_i.dat;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  assign req_o   = req_reg;
  assign dat_o   = (count_reg == '0) ? 32'h0 : mem[rd_ptr_reg];
  assign empty_o = (count_reg == '0);
  assign count_o = count_reg;
  assign err_o   = err_reg;
endmodule
